// File: rtl/division_core.sv
// Sequential unsigned radix-2 restoring divider with a start/done handshake.
// One quotient bit is resolved per clock. Divide-by-zero returns all ones and is flagged.
module division_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Res,
    output logic [WIDTH-1:0] Rem,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] dq_reg;        // dividend shifts out of the MSB, quotient shifts into the LSB
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH-1:0] prem_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] rem_reg;
    logic             dbz_pend_reg;
    logic             dbz_reg;
    logic             done_reg;
    logic             busy_reg;

    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] prem_next;

    // The compare is WIDTH+1 bits wide so divisors with the MSB set are handled.
    // When it succeeds the difference is below the divisor, so WIDTH bits hold it.
    always_comb begin
        shifted   = {prem_reg, dq_reg[WIDTH-1]};
        ge        = (shifted >= {1'b0, divisor_reg});
        prem_next = shifted[WIDTH-1:0] - (ge ? divisor_reg : '0);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (B == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (count_reg == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            dq_reg       <= '0;
            divisor_reg  <= '0;
            prem_reg     <= '0;
            res_reg      <= '0;
            rem_reg      <= '0;
            dbz_pend_reg <= 1'b0;
            dbz_reg      <= 1'b0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == RUN);
            done_reg  <= (state_reg == DONE);
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        divisor_reg <= B;
                        count_reg   <= CW'(WIDTH);
                        if (B == '0) begin
                            // Preload the degenerate result so DONE publishes it uniformly
                            dq_reg       <= '1;
                            prem_reg     <= A;
                            dbz_pend_reg <= 1'b1;
                        end else begin
                            dq_reg       <= A;
                            prem_reg     <= '0;
                            dbz_pend_reg <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    dq_reg    <= {dq_reg[WIDTH-2:0], ge};
                    prem_reg  <= prem_next;
                    count_reg <= count_reg - CW'(1);
                end
                DONE: begin
                    res_reg <= dq_reg;
                    rem_reg <= prem_reg;
                    dbz_reg <= dbz_pend_reg;
                end
                default: ;
            endcase
        end
    end

    assign Res         = res_reg;
    assign Rem         = rem_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_division_core.sv
// Scoreboard bench for division_core: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is presented.
module tb_division_core;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A, B;
    logic [W-1:0] Res, Rem;
    logic         busy, done, div_by_zero;

    division_core #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .Res(Res), .Rem(Rem), .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a, b, res, rem;
        logic         dbz;
        longint       t0;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    longint       cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    int           done_cnt = 0;
    logic [W-1:0] last_res = '0;
    logic [W-1:0] last_rem = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Reference model: plain integer division, all-ones/A on zero divisor.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        e.a   = a;
        e.b   = b;
        e.dbz = (b == 0);
        e.res = (b == 0) ? {W{1'b1}} : a / b;
        e.rem = (b == 0) ? a : a % b;
        e.t0  = cyc;
        e.lat = (b == 0) ? 1 : W + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n0 = done_cnt;
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (done_cnt != n0) begin
                ok = 1'b1;
                break;
            end
        end
        chk({"done_seen_", tag}, 64'(ok), 64'd1);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res", 64'(Res), 64'(e.res));
                chk("rem", 64'(Rem), 64'(e.rem));
                chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                chk("latency", 64'(cyc - e.t0), 64'(e.lat));
                if (!e.dbz) begin
                    chk("rem_below_b", 64'(Rem < e.b), 64'd1);
                    chk("reconstruct", 64'(Res) * 64'(e.b) + 64'(Rem), 64'(e.a));
                end
                $display("txn %0d / %0d -> Res=%0d Rem=%0d dbz=%0b", e.a, e.b, Res, Rem, div_by_zero);
                last_res = e.res;
                last_rem = e.rem;
            end
            done_cnt++;
        end
    end

    logic [W-1:0] ex_a[4] = '{16'd100, 16'd200, 16'd90, 16'd70};
    logic [W-1:0] ex_b[4] = '{16'd10, 16'd40, 16'd9, 16'd10};
    logic [W-1:0] in_a[5] = '{16'd16, 16'd255, 16'd65535, 16'd5, 16'd65535};
    logic [W-1:0] in_b[5] = '{16'd3, 16'd5, 16'd1, 16'd7, 16'd32768};

    initial begin
        logic [W-1:0] ra, rb;
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_res", 64'(Res), 64'd0);
        chk("reset_rem", 64'(Rem), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dbz", 64'(div_by_zero), 64'd0);

        issue(16'd0, 16'd0);
        wait_done("zero");

        for (int i = 0; i < 4; i++) begin
            issue(ex_a[i], ex_b[i]);
            chk("busy_in_run", 64'(busy), 64'd1);
            wait_done("exact");
        end
        for (int i = 0; i < 5; i++) begin
            issue(in_a[i], in_b[i]);
            wait_done("inexact");
        end

        // Start pulses and operand changes during RUN must not disturb the result
        issue(16'd100, 16'd10);
        repeat (3) @(negedge clk);
        A = 16'd5; B = 16'd0; start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0; A = 16'd1234;
        wait_done("mid_run_start");
        issue(16'd16, 16'd3);
        wait_done("back_to_back");
        repeat (5) @(negedge clk);
        chk("hold_res", 64'(Res), 64'(last_res));
        chk("hold_rem", 64'(Rem), 64'(last_rem));
        chk("idle_busy", 64'(busy), 64'd0);

        // Reset partway through a division
        issue(16'd100, 16'd10);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        chk("midrst_res", 64'(Res), 64'd0);
        chk("midrst_rem", 64'(Rem), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(16'd16, 16'd3);
        wait_done("after_reset");

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            if ($urandom_range(3) == 0) rb = W'($urandom_range(15, 1));
            else rb = W'($urandom_range(65535, 1));
            issue(ra, rb);
            wait_done("random");
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
